// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: issues in-order fetches, buffers responses in a
// small in-order queue and feeds (pc, inst) pairs into the IF/ID register.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_gnt_i,
  input  logic        inst_rvalid_i,
  input  logic [31:0] inst_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [31:0]          pc_q, pc_d;
  logic [BUF_DEPTH-1:0] alloc_q, alloc_d;
  logic [BUF_DEPTH-1:0] filled_q, filled_d;
  logic [31:0]          epc_q   [BUF_DEPTH];
  logic [31:0]          epc_d   [BUF_DEPTH];
  logic [31:0]          einst_q [BUF_DEPTH];
  logic [31:0]          einst_d [BUF_DEPTH];
  logic [PW-1:0]        aptr_q, aptr_d;
  logic [PW-1:0]        fptr_q, fptr_d;
  logic [PW-1:0]        hptr_q, hptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CW-1:0]        disc_q, disc_d;
  logic                 if_valid_q, if_valid_d;
  logic [31:0]          if_pc_q, if_pc_d;
  logic [31:0]          if_inst_q, if_inst_d;

  logic                 redirect;
  logic                 req;
  logic                 grant;
  logic                 resp_drop;
  logic                 resp_fill;
  logic                 pop;
  logic [CW-1:0]        unfilled;
  logic [CW:0]          outstanding;
  logic [CW-1:0]        disc_redirect;
  logic                 unused_stall;

  assign unused_stall = ^stall_i[6:2];

  assign redirect  = flush_i | branch_flag_i;
  assign req       = !stall_i[0] && !redirect && (cnt_q < DEPTH_C);
  assign grant     = req && inst_gnt_i;
  assign resp_drop = inst_rvalid_i && (disc_q != '0);
  assign resp_fill = inst_rvalid_i && (disc_q == '0) &&
                     alloc_q[fptr_q] && !filled_q[fptr_q];
  // Only entries filled before this edge may be forwarded.
  assign pop       = !stall_i[1] && filled_q[hptr_q];

  always_comb begin
    unfilled = '0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      unfilled = unfilled + CW'(alloc_q[i] & ~filled_q[i]);
    end
  end

  // Everything still in flight at the memory becomes wrong-path on a redirect;
  // a response landing in the redirect cycle is itself one of them.
  always_comb begin
    outstanding = {1'b0, disc_q} + {1'b0, unfilled};
    if (inst_rvalid_i && (outstanding != '0)) begin
      outstanding = outstanding - (CW+1)'(1);
    end
    disc_redirect = outstanding[CW] ? {CW{1'b1}} : outstanding[CW-1:0];
  end

  always_comb begin
    pc_d       = pc_q;
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    epc_d      = epc_q;
    einst_d    = einst_q;
    aptr_d     = aptr_q;
    fptr_d     = fptr_q;
    hptr_d     = hptr_q;
    cnt_d      = cnt_q;
    disc_d     = disc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;

    if (redirect) begin
      pc_d     = flush_i ? new_pc_i : branch_target_i;
      alloc_d  = '0;
      filled_d = '0;
      aptr_d   = '0;
      fptr_d   = '0;
      hptr_d   = '0;
      cnt_d    = '0;
      disc_d   = disc_redirect;
      if (flush_i || !stall_i[1]) begin
        if_valid_d = 1'b0;
      end
    end else begin
      if (resp_drop) begin
        disc_d = disc_q - CW'(1);
      end
      if (resp_fill) begin
        einst_d[fptr_q]  = inst_rdata_i;
        filled_d[fptr_q] = 1'b1;
        fptr_d           = fptr_q + PW'(1);
      end
      if (!stall_i[1]) begin
        if (pop) begin
          if_valid_d       = 1'b1;
          if_pc_d          = epc_q[hptr_q];
          if_inst_d        = einst_q[hptr_q];
          alloc_d[hptr_q]  = 1'b0;
          filled_d[hptr_q] = 1'b0;
          hptr_d           = hptr_q + PW'(1);
        end else begin
          if_valid_d = 1'b0;
        end
      end
      if (grant) begin
        alloc_d[aptr_q]  = 1'b1;
        filled_d[aptr_q] = 1'b0;
        epc_d[aptr_q]    = pc_q;
        aptr_d           = aptr_q + PW'(1);
        pc_d             = pc_q + 32'd4;
      end
      case ({grant, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      alloc_q    <= '0;
      filled_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        epc_q[i]   <= '0;
        einst_q[i] <= '0;
      end
      aptr_q     <= '0;
      fptr_q     <= '0;
      hptr_q     <= '0;
      cnt_q      <= '0;
      disc_q     <= '0;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      filled_q   <= filled_d;
      epc_q      <= epc_d;
      einst_q    <= einst_d;
      aptr_q     <= aptr_d;
      fptr_q     <= fptr_d;
      hptr_q     <= hptr_d;
      cnt_q      <= cnt_d;
      disc_q     <= disc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
    end
  end

  assign inst_req_o  = req;
  assign inst_addr_o = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: queue-based reference model plus an in-order
// memory responder with adjustable latency, and directed scenarios.
module tb_pc_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [6:0]  stall_i;
  logic        flush_i;
  logic [31:0] new_pc_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_gnt_i;
  logic        inst_rvalid_i;
  logic [31:0] inst_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .new_pc_i(new_pc_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .inst_req_o(inst_req_o),
    .inst_addr_o(inst_addr_o), .inst_gnt_i(inst_gnt_i),
    .inst_rvalid_i(inst_rvalid_i), .inst_rdata_i(inst_rdata_i),
    .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    bit          filled;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  int          m_disc = 0;
  logic [31:0] m_pc = RPC;
  bit          m_v = 1'b0;
  logic [31:0] m_ifpc = '0;
  logic [31:0] m_ifinst = '0;
  bit          m_g;
  bit          m_popv;

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  function automatic bit m_req();
    return !stall_i[0] && !flush_i && !branch_flag_i && (mq.size() < DEPTH);
  endfunction

  task automatic m_apply_resp();
    bit done = 1'b0;
    if (inst_rvalid_i) begin
      if (m_disc > 0) m_disc--;
      else begin
        foreach (mq[i]) begin
          if (!done && !mq[i].filled) begin
            mq[i].filled = 1'b1;
            mq[i].inst   = inst_rdata_i;
            done         = 1'b1;
          end
        end
      end
    end
  endtask

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_disc = 0; m_pc = RPC; m_v = 1'b0; m_ifpc = '0; m_ifinst = '0;
    end else begin
      m_g = m_req() && inst_gnt_i;
      if (flush_i || branch_flag_i) begin
        m_apply_resp();
        m_disc = m_disc + m_unfilled();
        mq.delete();
        m_pc = flush_i ? new_pc_i : branch_target_i;
        if (flush_i || !stall_i[1]) m_v = 1'b0;
      end else begin
        m_popv = !stall_i[1] && (mq.size() > 0) && mq[0].filled;
        m_apply_resp();
        if (!stall_i[1]) begin
          if (m_popv) begin
            m_v = 1'b1; m_ifpc = mq[0].pc; m_ifinst = mq[0].inst;
            void'(mq.pop_front());
          end else m_v = 1'b0;
        end
        if (m_g) begin
          mq.push_back('{m_pc, 1'b0, 32'h0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] grants[$];
  int          cyc = 0;
  int          mem_lat = 1;

  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      memq.delete();
      inst_rvalid_i = 1'b0;
      inst_rdata_i  = '0;
    end else begin
      cyc++;
      if (inst_rvalid_i && memq.size() > 0) void'(memq.pop_front());
      if (inst_req_o && inst_gnt_i) begin
        memq.push_back('{inst_addr_o, cyc + mem_lat - 1});
        grants.push_back(inst_addr_o);
      end
      #1;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
        inst_rvalid_i = 1'b1;
        inst_rdata_i  = inst_of(memq[0].a);
      end else begin
        inst_rvalid_i = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(negedge clk);
    chk("if_valid", {31'b0, if_valid_o}, {31'b0, m_v});
    chk("if_pc", if_pc_o, m_ifpc);
    chk("if_inst", if_inst_o, m_ifinst);
    chk("inst_req", {31'b0, inst_req_o}, {31'b0, m_req()});
    chk("inst_addr", inst_addr_o, m_pc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Collect the next n valid IF/ID pcs (bounded).
  task automatic collect(input int n, output logic [31:0] p0, output logic [31:0] p1, output bit ok);
    int got = 0;
    p0 = '0; p1 = '0;
    for (int i = 0; i < 60 && got < n; i++) begin
      step();
      if (if_valid_o) begin
        if (got == 0) p0 = if_pc_o; else p1 = if_pc_o;
        got++;
      end
    end
    ok = (got == n);
  endtask

  logic [31:0] p0, p1;
  bit          ok, found;
  int          e, n0;

  initial begin
    rst_n = 1'b0; stall_i = '0; flush_i = 1'b0; new_pc_i = '0;
    branch_flag_i = 1'b0; branch_target_i = '0; inst_gnt_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("reset_addr", inst_addr_o, RPC);
    rst_n = 1'b1;

    // T1: first output three edges after reset release, pc 0
    e = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (if_valid_o) found = 1'b1;
    end
    chk("t1_first_valid_edge", e, 3);
    chk("t1_first_pc", if_pc_o, 32'h0);
    chk("t1_first_inst", if_inst_o, inst_of(32'h0));

    // T2: full stall while IF/ID shows 0x8
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (if_valid_o && if_pc_o == 32'h8) found = 1'b1;
    end
    chk("t2_reach_8", {31'b0, found}, 32'd1);
    chk("t1_grant0", grants[0], 32'h0);
    chk("t1_grant1", grants[1], 32'h4);
    chk("t1_grant2", grants[2], 32'h8);
    stall_i = 7'b0111111;
    repeat (5) begin
      @(negedge clk);
      chk("t2_req_low", {31'b0, inst_req_o}, 32'd0);
      chk("t2_hold_pc", if_pc_o, 32'h8);
      chk("t2_hold_valid", {31'b0, if_valid_o}, 32'd1);
    end
    step();
    stall_i = '0;
    collect(2, p0, p1, ok);
    chk("t2_collect", {31'b0, ok}, 32'd1);
    chk("t2_next_pc0", p0, 32'hC);
    chk("t2_next_pc1", p1, 32'h10);

    // T3: drain, then hold only the IF/ID stage
    stall_i = 7'b0000001;
    repeat (8) step();
    stall_i = 7'b0000010;
    n0 = grants.size();
    repeat (10) step();
    @(negedge clk);
    chk("t3_grants", grants.size() - n0, DEPTH);
    chk("t3_req_low", {31'b0, inst_req_o}, 32'd0);
    step();
    stall_i = '0;
    collect(2, p0, p1, ok);
    chk("t3_collect", {31'b0, ok}, 32'd1);
    chk("t3_order", p1, p0 + 32'd4);
    chk("t3_first", p0, grants[n0]);

    // T4: flush to 0xC with two requests outstanding
    mem_lat = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (m_unfilled() == 2 && m_disc == 0) found = 1'b1;
    end
    chk("t4_two_outstanding", {31'b0, found}, 32'd1);
    flush_i = 1'b1; new_pc_i = 32'h0000_000C;
    step();
    flush_i = 1'b0;
    @(negedge clk);
    chk("t4_valid_low", {31'b0, if_valid_o}, 32'd0);
    chk("t4_addr", inst_addr_o, 32'hC);
    collect(1, p0, p1, ok);
    chk("t4_collect", {31'b0, ok}, 32'd1);
    chk("t4_first_pc", p0, 32'hC);
    chk("t4_first_inst", if_inst_o, inst_of(32'hC));
    mem_lat = 1;

    // T5: branch to 0x100 in the cycle the response for 0x8 arrives
    step();
    flush_i = 1'b1; new_pc_i = 32'h8; mem_lat = 2;
    step();
    flush_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (inst_rvalid_i && memq.size() > 0 && memq[0].a == 32'h8 && m_disc == 0) found = 1'b1;
      else step();
    end
    chk("t5_resp_seen", {31'b0, found}, 32'd1);
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    @(negedge clk);
    chk("t5_addr", inst_addr_o, 32'h100);
    chk("t5_valid_low", {31'b0, if_valid_o}, 32'd0);
    collect(1, p0, p1, ok);
    chk("t5_collect", {31'b0, ok}, 32'd1);
    chk("t5_first_pc", p0, 32'h100);
    mem_lat = 1;

    // T6: asynchronous reset with filled entries
    stall_i = 7'b0000010;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, if_valid_o}, 32'd0);
    chk("t6_async_pc", if_pc_o, 32'h0);
    chk("t6_async_inst", if_inst_o, 32'h0);
    chk("t6_async_addr", inst_addr_o, RPC);
    stall_i = '0;
    step();
    step();
    n0 = grants.size();
    rst_n = 1'b1;
    collect(1, p0, p1, ok);
    chk("t6_collect", {31'b0, ok}, 32'd1);
    chk("t6_first_pc", p0, RPC);
    chk("t6_first_grant", grants[n0], RPC);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
